// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial adder controller, one full-adder cell stepped LSB first over WIDTH cycles.
// Optional build macro SERIAL_ADD_SUB_EN adds a 'sub' port for two's-complement subtraction.

module fa_1bit (
   input  logic i0,
   input  logic i1,
   input  logic cin,
   output logic cout,
   output logic sum
);
   assign sum  = i0 ^ i1 ^ cin;
   assign cout = (i0 & i1) | (cin & (i0 ^ i1));
endmodule

module serial_add_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);
   localparam int CW = $clog2(WIDTH);

   typedef enum logic {IDLE, RUN} state_t;

   state_t           state, state_nx;
   logic [CW-1:0]    cnt;
   logic             carry;
   logic [WIDTH-1:0] opa, opb, sr, sr_nx, b_cap;
   logic             c_cap, fa_c, fa_s, last;

`ifdef SERIAL_ADD_SUB_EN
   assign b_cap = sub ? ~b : b;
   assign c_cap = sub | cin;
`else
   assign b_cap = b;
   assign c_cap = cin;
`endif

   assign last  = cnt == CW'(WIDTH - 1);
   assign busy  = state == RUN;
   assign sr_nx = WIDTH'({fa_s, sr} >> 1);

   fa_1bit u_fa (
      .i0  (opa[0]),
      .i1  (opb[0]),
      .cin (carry),
      .cout(fa_c),
      .sum (fa_s)
   );

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // next state: accept start when idle, return to idle after the last bit step
   always_comb begin
      state_nx = state;
      if (state == IDLE) state_nx = start ? RUN : IDLE;
      else               state_nx = last ? IDLE : RUN;
   end

   // datapath: operand capture, bit stepping, result commit and done pulse
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt   <= '0;
         carry <= 1'b0;
         opa   <= '0;
         opb   <= '0;
         sr    <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (start) begin
               opa   <= a;
               opb   <= b_cap;
               carry <= c_cap;
               cnt   <= '0;
            end
         end else begin
            carry <= fa_c;
            sr    <= sr_nx;
            opa   <= opa >> 1;
            opb   <= opb >> 1;
            cnt   <= cnt + 1'b1;
            if (last) begin
               sum  <= sr_nx;
               cout <= fa_c;
               done <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: vector table, corner sequences and random checks against an arithmetic model.

module tb_serial_add_ctrl;
   localparam int W = 8;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         c;
      logic         s;
      logic [W-1:0] es;
      logic         ec;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         cin = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy, done, cout;
   logic [W-1:0] sum;
`ifdef SERIAL_ADD_SUB_EN
   logic         sub = 1'b0;
`endif

   int checks = 0;
   int failures = 0;

   serial_add_ctrl #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .start(start),
      .a    (a),
      .b    (b),
      .cin  (cin),
`ifdef SERIAL_ADD_SUB_EN
      .sub  (sub),
`endif
      .busy (busy),
      .done (done),
      .sum  (sum),
      .cout (cout)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
      end
   endtask

   function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic c, input logic s);
      logic [W-1:0] ny;
      ny = ~y;
      return s ? ({1'b0, x} + {1'b0, ny} + (W+1)'(1)) : ({1'b0, x} + {1'b0, y} + (W+1)'(c));
   endfunction

   task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tc, input logic ts);
      a   = ta;
      b   = tb2;
      cin = tc;
`ifdef SERIAL_ADD_SUB_EN
      sub = ts;
`else
      if (ts) $display("note: subtract request dropped in add-only build");
`endif
      start = 1'b1;
      tick;
      start = 1'b0;
   endtask

   task automatic wait_done(output int n, output int bc);
      n  = 0;
      bc = int'(busy);
      while (!done && n < 4 * W) begin
         tick;
         n++;
         if (!done) bc += int'(busy);
      end
   endtask

   task automatic run_op(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb2,
                         input logic tc, input logic ts, input logic [W:0] exp);
      int n, bc;
      launch(ta, tb2, tc, ts);
      wait_done(n, bc);
      chk({nm, "_latency"}, n, W);
      chk({nm, "_busy_cycles"}, bc, W);
      chk({nm, "_busy_at_done"}, busy, 0);
      chk({nm, "_sum"}, sum, exp[W-1:0]);
      chk({nm, "_cout"}, cout, exp[W]);
   endtask

   vec_t vecs[$];

   initial begin
      int n, bc, dones;
      logic [W:0]   exp;
      logic [W-1:0] ra, rb;
      logic         rc, rs;

      vecs.push_back('{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0});
      vecs.push_back('{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1});
      vecs.push_back('{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1});
      vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0});
      vecs.push_back('{8'hAA, 8'h55, 1'b1, 1'b0, 8'h00, 1'b1});
      vecs.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1});
      vecs.push_back('{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0});
`ifdef SERIAL_ADD_SUB_EN
      vecs.push_back('{8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0});
      vecs.push_back('{8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1});
      vecs.push_back('{8'h07, 8'h05, 1'b1, 1'b1, 8'h02, 1'b1});
`endif

      rst_n = 1'b0;
      tick;
      tick;
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_sum", sum, 0);
      chk("reset_cout", cout, 0);
      rst_n = 1'b1;
      tick;
      chk("idle_busy", busy, 0);

      // table vectors, issued back-to-back in the done cycle of the previous one
      foreach (vecs[i]) begin
         run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].s,
                {vecs[i].ec, vecs[i].es});
      end

      // done is a single-cycle pulse and results hold while idle
      tick;
      chk("done_pulse_width", done, 0);
      repeat (3) tick;
      chk("hold_sum", sum, vecs[vecs.size()-1].es);
      chk("hold_cout", cout, vecs[vecs.size()-1].ec);

      // second start while busy is ignored and not queued
      launch(8'h12, 8'h34, 1'b0, 1'b0);
      tick;
      tick;
      a = 8'hAA;
      b = 8'h55;
      start = 1'b1;
      tick;
      start = 1'b0;
      a = 8'h00;
      b = 8'h00;
      wait_done(n, bc);
      chk("ignore_latency", n, W - 3);
      chk("ignore_sum", sum, 8'h46);
      chk("ignore_cout", cout, 0);
      dones = 0;
      repeat (2 * W + 2) begin
         tick;
         dones += int'(done);
      end
      chk("ignore_extra_done", dones, 0);

      // reset in the middle of a run aborts it
      run_op("pre_abort", 8'hF0, 8'h0F, 1'b1, 1'b0, model(8'hF0, 8'h0F, 1'b1, 1'b0));
      launch(8'h80, 8'h80, 1'b0, 1'b0);
      repeat (3) tick;
      rst_n = 1'b0;
      tick;
      rst_n = 1'b1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_sum", sum, 0);
      chk("abort_cout", cout, 0);
      dones = 0;
      repeat (W + 2) begin
         tick;
         dones += int'(done);
      end
      chk("abort_no_done", dones, 0);
      run_op("post_abort", 8'h0F, 8'h01, 1'b0, 1'b0, 9'h010);

      // random operations against the arithmetic model, with random idle gaps
      for (int i = 0; i < 40; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
`ifdef SERIAL_ADD_SUB_EN
         rs = 1'($urandom);
`else
         rs = 1'b0;
`endif
         exp = model(ra, rb, rc, rs);
         run_op($sformatf("rnd%0d", i), ra, rb, rc, rs, exp);
         if ($urandom_range(1, 0) == 1) begin
            repeat ($urandom_range(4, 1)) tick;
            chk($sformatf("rnd%0d_hold", i), {cout, sum}, exp);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
